instr_fetch_seq: RTL
====================

Name: instr_fetch_seq

Overview:
Synthesizable burst instruction-fetch sequencer. It drives a RAM2Kx32-style synchronous SRAM port (CEN/WEN/OEN/A/Q, active-low controls) and streams fetched words out over a valid/ready interface. Each word leaves already split into the ISA fields (opcode, dr, sa, sb, imm, sh) together with an illegal-opcode flag. It sits between the instruction memory and the decode stage, and it is also the hardware fetch engine for the bench loader.

Parameters:
ADDR_W, 11, memory address width; depth is 2^ADDR_W words.
DATA_W, 32, instruction width; must be at least 32.
CNT_W, 12, width of the burst length field.
PIPELINED, 0, 0 = two-cycle read per word; 1 = back-to-back reads, one word per cycle.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  starts a burst; sampled only in IDLE.
start_addr  in  ADDR_W  first word address.
count  in  CNT_W  number of words to fetch.
abort  in  1  synchronous burst cancel.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse when a burst ends.
mem_cen  out  1  SRAM chip enable, active low.
mem_wen  out  1  SRAM write enable; tied to 1.
mem_oen  out  1  SRAM output enable, active low.
mem_addr  out  ADDR_W  SRAM address.
mem_q  in  DATA_W  SRAM read data.
out_valid  out  1  an output word is present.
out_ready  in  1  the consumer accepts the word.
out_ir  out  DATA_W  raw instruction word.
out_pc  out  ADDR_W  address the word was fetched from.
out_opcode  out  7  ir[31:25].
out_dr  out  5  ir[24:20].
out_sa  out  5  ir[19:15].
out_sb  out  5  ir[14:10].
out_imm  out  DATA_W  ir[14:0], sign-extended.
out_sh  out  5  ir[4:0].
out_illegal  out  1  opcode is not in the legal set.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE and both output-FIFO entries are empty.
  - mem_cen=1, mem_oen=1, mem_wen=1, mem_addr=0.
  - busy=0, done=0, out_valid=0.
  - All out_* data outputs are 0.
  - Reset mid-burst drops all in-flight data with no done pulse.
- SRAM timing:
  - The SRAM samples mem_addr at the clock edge where mem_cen=0.
  - mem_q is valid during the following cycle, and only while mem_oen=0.
  - mem_oen is 0 in every cycle where a read result is captured, and 1 otherwise.
- States: IDLE, ISSUE, WAIT (used only when PIPELINED=0), DRAIN.
  - IDLE, start=1, count!=0: latch start_addr and count, go to ISSUE.
  - IDLE, start=1, count=0: no memory access; done pulses on the next cycle.
  - ISSUE: issue one read (mem_cen=0, mem_addr=current address) only when the credit rule allows it. Otherwise hold with mem_cen=1.
  - PIPELINED=0: each issue is followed by WAIT, where mem_q is captured, then return to ISSUE. Throughput is one word per 2 cycles.
  - PIPELINED=1: ISSUE can issue every cycle while capturing the previous read in the same cycle. Throughput is one word per cycle when out_ready is held high.
  - After the last read is issued, go to DRAIN. Leave DRAIN for IDLE once the final capture is done and the FIFO is empty; done pulses in the cycle the state returns to IDLE.
- Address:
  - Increments by 1 per issued read, modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
  - out_pc carries the address that was actually issued for that word.
- Output buffer:
  - 2-entry FIFO holding the captured ir and pc; the decoded fields are combinational from the head entry.
  - Credit rule: a read is issued only if (FIFO occupancy + reads in flight) < 2. No word is ever lost under backpressure.
  - When out_valid=1 and out_ready=0, the head entry and all out_* stay stable.
  - A pop and a push in the same cycle are both allowed and leave the occupancy unchanged.
- Legal opcodes (out_illegal=0):
  - 0000000, 1000000, 0000010, 0000101, 0001000, 0001001, 0001010, 0001011
  - 0100010, 0100101, 0101000, 0101001, 0101010, 0001100, 0001101, 0001110
  - 0010000, 0100000, 1110000, 1100101, 1100000, 1001000, 1101000, 0110000
  - Any other opcode sets out_illegal=1. The word is still delivered.
- abort:
  - In a non-IDLE state: stop issuing on the next edge, discard in-flight reads and FIFO contents, go to IDLE, pulse done.
  - Ignored in IDLE.
  - abort has priority over start.
- start while busy is ignored.

Test Plan:
1. PIPELINED=0, RAM words 0..4 = 0x04000000+k, start_addr=0, count=5, out_ready=1 -> 5 words with out_pc 0..4, one every 2 cycles, out_opcode=0000010; done pulses once; busy=0 afterwards.
2. PIPELINED=1, count=8, out_ready=1 -> after the first word, out_valid stays high for 8 consecutive cycles; mem_cen is low for 8 consecutive cycles.
3. PIPELINED=1, count=6, out_ready toggled 1,0,0,1,0,1… -> exactly 6 words in order, no duplicates; data stable while stalled; occupancy never exceeds 2.
4. start_addr=2046, count=4 -> out_pc sequence 2046, 2047, 0, 1.
5. Word 0xFE007FFF -> out_opcode=1111111, out_illegal=1, out_imm=0xFFFFFFFF, out_sh=31. Word 0x4010_8005 -> opcode ADI, out_imm=5, dr=1, sa=1.
6. Corner cases:
   - count=0 -> done 1 cycle later, mem_cen never low.
   - abort on the 3rd word of a count=10 burst -> done pulse, out_valid=0 next cycle, no further mem_cen=0.
   - rst_n low mid-burst -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Burst instruction-fetch sequencer: reads a synchronous single-port SRAM and
// streams the words, split into ISA fields, through a 2-entry valid/ready buffer.
module instr_fetch_seq #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 12,
  parameter int PIPELINED = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_cen,
  output logic              mem_wen,
  output logic              mem_oen,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
  output logic [ADDR_W-1:0] out_pc,
  output logic [6:0]        out_opcode,
  output logic [4:0]        out_dr,
  output logic [4:0]        out_sa,
  output logic [4:0]        out_sb,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_sh,
  output logic              out_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic              oen_q, oen_d;
  logic [ADDR_W-1:0] cap_pc_q, cap_pc_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_ir_q [2];
  logic [DATA_W-1:0] fifo_ir_d [2];
  logic [ADDR_W-1:0] fifo_pc_q [2];
  logic [ADDR_W-1:0] fifo_pc_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              push;
  logic              pop;
  logic [1:0]        credit_used;
  logic              issue;
  logic [DATA_W-1:0] head_ir;

  // Handshake, credit and issue decision; mem_cen must see this cycle's pop to sustain one word per cycle
  always_comb begin
    push        = ~oen_q;
    out_valid   = (cnt_q != 2'd0);
    pop         = out_valid & out_ready;
    credit_used = cnt_q - {1'b0, pop} + {1'b0, push};
    issue       = (state_q == S_ISSUE) && (credit_used < 2'd2) && !abort;
    mem_cen     = ~issue;
    mem_wen     = 1'b1;
    mem_oen     = oen_q;
    mem_addr    = addr_q;
    busy        = (state_q != S_IDLE);
    done        = done_q;
  end

  // Next-state logic for the sequencer, the capture pipeline and the output buffer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    oen_d     = ~issue;
    cap_pc_d  = issue ? addr_q : cap_pc_q;
    done_d    = 1'b0;
    fifo_ir_d = fifo_ir_q;
    fifo_pc_d = fifo_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      fifo_ir_d[wr_ptr_q] = mem_q;
      fifo_pc_d[wr_ptr_q] = cap_pc_q;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_d   = start_addr;
            remain_d = count;
            state_d  = S_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end else if (PIPELINED == 0) begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (oen_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      done_d   = 1'b1;
      oen_d    = 1'b1;
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      oen_q    <= 1'b1;
      cap_pc_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_ir_q[i] <= '0;
        fifo_pc_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      oen_q     <= oen_d;
      cap_pc_q  <= cap_pc_d;
      done_q    <= done_d;
      fifo_ir_q <= fifo_ir_d;
      fifo_pc_q <= fifo_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Field split of the head entry; outputs read as zero while no word is present
  always_comb begin
    head_ir     = out_valid ? fifo_ir_q[rd_ptr_q] : '0;
    out_ir      = head_ir;
    out_pc      = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
    out_opcode  = head_ir[31:25];
    out_dr      = head_ir[24:20];
    out_sa      = head_ir[19:15];
    out_sb      = head_ir[14:10];
    out_imm     = {{(DATA_W-15){head_ir[14]}}, head_ir[14:0]};
    out_sh      = head_ir[4:0];
    case (head_ir[31:25])
      7'b0000000, 7'b1000000, 7'b0000010, 7'b0000101,
      7'b0001000, 7'b0001001, 7'b0001010, 7'b0001011,
      7'b0100010, 7'b0100101, 7'b0101000, 7'b0101001,
      7'b0101010, 7'b0001100, 7'b0001101, 7'b0001110,
      7'b0010000, 7'b0100000, 7'b1110000, 7'b1100101,
      7'b1100000, 7'b1001000, 7'b1101000, 7'b0110000: out_illegal = 1'b0;
      default:                                         out_illegal = 1'b1;
    endcase
  end

endmodule
